// File: rtl/rv32m_div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states, constants.
package rv32m_pkg;
   localparam int unsigned XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FAST,
      S_DONE
   } state_e;

   localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT = '1;
endpackage

// File: rtl/rv32m_div_unit_if.sv
// Issue/write-back bundle between the pipeline and the divider.
interface rv32m_div_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [4:0]      rd_addr_i;
   logic            busy_o;
   logic            done_o;
   logic            wr_en_o;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
      input  busy_o, done_o, wr_en_o, rd_addr_o, result_o
   );

   modport slave (
      input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
      output busy_o, done_o, wr_en_o, rd_addr_o, result_o
   );
endinterface

// File: rtl/rv32m_div_unit_div_core_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor magnitude.
module div_core_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN:0]   i_dvsr,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);
   logic [XLEN:0] w_rem_sh;
   logic          w_ge;

   always_comb begin
      w_rem_sh = {i_rem, i_quo[XLEN-1]};
      w_ge     = (w_rem_sh >= i_dvsr);
      // A kept remainder is always below the divisor, so it fits in XLEN bits.
      o_rem    = w_ge ? XLEN'(w_rem_sh - i_dvsr) : XLEN'(w_rem_sh);
      o_quo    = {i_quo[XLEN-2:0], w_ge};
   end
endmodule

// File: rtl/rv32m_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: XLEN-cycle radix-2 divider with a one-cycle path for
// divide-by-zero and signed overflow, driving the register-file write port on completion.
module rv32m_div_unit
   import rv32m_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input logic              clk,
   input logic              rst,
   rv32m_div_unit_if.slave  bus
);
   localparam int unsigned CW = $clog2(XLEN);

   state_e          r_state;
   state_e          w_next;
   op_e             r_op;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_rem;
   logic [XLEN:0]   r_dvsr;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rd;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_div0;

   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN:0]   w_b_mag;
   logic [XLEN-1:0] w_rem_nx;
   logic [XLEN-1:0] w_quo_nx;
   logic            w_is_rem;
   logic            w_last;
   logic [XLEN-1:0] w_run_res;
   logic [XLEN-1:0] w_fast_res;

   always_comb begin
      w_signed = ~bus.op_i[0];
      w_a_neg  = w_signed & bus.rs1_data_i[XLEN-1];
      w_b_neg  = w_signed & bus.rs2_data_i[XLEN-1];
      w_div0   = (bus.rs2_data_i == '0);
      w_ovf    = w_signed && (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.rs2_data_i == '1);
      // Magnitudes are formed in XLEN+1 bits so that |-2^(XLEN-1)| is exact.
      w_a_mag  = w_a_neg ? XLEN'(-{1'b1, bus.rs1_data_i}) : bus.rs1_data_i;
      w_b_mag  = w_b_neg ? -{1'b1, bus.rs2_data_i} : {1'b0, bus.rs2_data_i};
   end

   div_core_step #(.XLEN(XLEN)) u_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_dvsr (r_dvsr),
      .o_rem  (w_rem_nx),
      .o_quo  (w_quo_nx)
   );

   always_comb begin
      w_is_rem   = (r_op == OP_REM) || (r_op == OP_REMU);
      w_last     = (r_cnt == CW'(XLEN - 1));
      w_run_res  = w_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                            : (r_neg_q ? -w_quo_nx : w_quo_nx);
      // Fast path: zero divisor or signed overflow (where r_a already equals the min value).
      if (r_div0) w_fast_res = w_is_rem ? r_a : XLEN'(DIV0_QUOT);
      else        w_fast_res = w_is_rem ? '0  : r_a;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start_i) w_next = (w_div0 || w_ovf) ? S_FAST : S_RUN;
         S_RUN:  if (w_last) w_next = S_DONE;
         S_FAST: w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= OP_DIV;
         r_a      <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dvsr   <= '0;
         r_result <= '0;
         r_rd     <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start_i) begin
               r_op    <= op_e'(bus.op_i);
               r_a     <= bus.rs1_data_i;
               r_quo   <= w_a_mag;
               r_rem   <= '0;
               r_dvsr  <= w_b_mag;
               r_rd    <= bus.rd_addr_i;
               r_cnt   <= '0;
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               r_div0  <= w_div0;
            end
            S_RUN: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) r_result <= w_run_res;
            end
            S_FAST: r_result <= w_fast_res;
            default: ;
         endcase
      end
   end

   assign bus.busy_o    = (r_state != S_IDLE);
   assign bus.done_o    = (r_state == S_DONE);
   assign bus.wr_en_o   = (r_state == S_DONE) && (r_rd != 5'd0);
   assign bus.rd_addr_o = r_rd;
   assign bus.result_o  = r_result;
endmodule

// File: tb/tb_rv32m_div_unit.sv
// Scoreboard bench for rv32m_div_unit: directed vectors queue expectations, a monitor checks completions.
module tb_rv32m_div_unit;
   import rv32m_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] res;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   int unsigned done_seen = 0;
   int unsigned last_done_cyc = 0;
   int unsigned acc_cyc;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv32m_div_unit_if #(.XLEN(32)) bus ();

   rv32m_div_unit #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.done_o) begin
         done_seen++;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: result=%h rd=%0d, required no completion",
                     bus.result_o, bus.rd_addr_o);
         end else begin
            e = sb.pop_front();
            chk("result", bus.result_o, e.res);
            chk("rd_addr", 32'(bus.rd_addr_o), 32'(e.rd));
            chk("wr_en", 32'(bus.wr_en_o), 32'(e.rd != 5'd0));
            chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", 32'(bus.busy_o), 32'd1);
         end
      end
      if (!rst && bus.wr_en_o && !bus.done_o) begin
         total++;
         bad++;
         $display("FAIL wr_en_without_done: wr_en=1, required 0");
      end
   end

   task automatic wait_idle();
      int unsigned n = 0;
      @(negedge clk);
      while ((bus.busy_o || bus.done_o) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy_o || bus.done_o) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: busy=%0b done=%0b, required both 0", bus.busy_o, bus.done_o);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input bit fast,
                        output int unsigned t_acc);
      wait_idle();
      t_acc          = cyc;
      bus.start_i    = 1'b1;
      bus.op_i       = op;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.rd_addr_i  = rd;
      sb.push_back('{rd: rd, res: res, cyc: cyc + 1 + (fast ? 1 : 32)});
      @(posedge clk);
      #1;
      bus.start_i    = 1'b0;
      bus.op_i       = 2'b00;
      bus.rs1_data_i = 32'hDEAD_BEEF;
      bus.rs2_data_i = 32'h0000_0000;
      bus.rd_addr_i  = 5'd31;
      @(negedge clk);
      chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
   endtask

   initial begin
      bus.start_i    = 1'b0;
      bus.op_i       = 2'b00;
      bus.rs1_data_i = '0;
      bus.rs2_data_i = '0;
      bus.rd_addr_i  = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(bus.busy_o), 32'd0);
      chk("reset_done", 32'(bus.done_o), 32'd0);
      chk("reset_wr_en", 32'(bus.wr_en_o), 32'd0);
      chk("reset_result", bus.result_o, 32'd0);
      chk("reset_rd", 32'(bus.rd_addr_o), 32'd0);
      rst = 1'b0;

      issue(2'b01, 32'd100,       32'd7,       5'd5,  32'd14,        1'b0, acc_cyc);
      issue(2'b00, 32'hFFFF_FFF9, 32'd2,       5'd1,  32'hFFFF_FFFD, 1'b0, acc_cyc);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2,       5'd2,  32'hFFFF_FFFF, 1'b0, acc_cyc);
      issue(2'b11, 32'hFFFF_FFF9, 32'd2,       5'd3,  32'd1,         1'b0, acc_cyc);
      issue(2'b00, 32'd7,         32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 1'b0, acc_cyc);
      issue(2'b10, 32'd7,         32'hFFFF_FFFE, 5'd6, 32'd1,         1'b0, acc_cyc);
      issue(2'b01, 32'd5,         32'd0,       5'd8,  32'hFFFF_FFFF, 1'b1, acc_cyc);
      issue(2'b10, 32'd5,         32'd0,       5'd9,  32'd5,         1'b1, acc_cyc);
      issue(2'b11, 32'd7,         32'd0,       5'd14, 32'd7,         1'b1, acc_cyc);
      issue(2'b00, 32'h1234_5678, 32'd0,       5'd15, 32'hFFFF_FFFF, 1'b1, acc_cyc);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, acc_cyc);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,        1'b1, acc_cyc);
      issue(2'b01, 32'hFFFF_FFFF, 32'd1,       5'd12, 32'hFFFF_FFFF, 1'b0, acc_cyc);
      issue(2'b00, 32'h8000_0000, 32'd2,       5'd13, 32'hC000_0000, 1'b0, acc_cyc);
      issue(2'b01, 32'd20,        32'd4,       5'd0,  32'd5,         1'b0, acc_cyc);

      // A start while busy must be ignored; the follow-up lands in the first idle cycle.
      issue(2'b01, 32'd1000, 32'd10, 5'd6, 32'd100, 1'b0, acc_cyc);
      repeat (3) @(negedge clk);
      bus.start_i    = 1'b1;
      bus.op_i       = 2'b01;
      bus.rs1_data_i = 32'd9;
      bus.rs2_data_i = 32'd3;
      bus.rd_addr_i  = 5'd7;
      @(negedge clk);
      bus.start_i    = 1'b0;
      chk("busy_during_ignored_start", 32'(bus.busy_o), 32'd1);
      issue(2'b01, 32'd9, 32'd3, 5'd7, 32'd3, 1'b0, acc_cyc);
      chk("back_to_back_accept", acc_cyc, last_done_cyc + 1);

      issue(2'b01, 32'd1000, 32'd10, 5'd3, 32'd100, 1'b0, acc_cyc);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      done_seen = 0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy_o), 32'd0);
      chk("abort_done", 32'(bus.done_o), 32'd0);
      chk("abort_result", bus.result_o, 32'd0);
      chk("abort_rd", 32'(bus.rd_addr_o), 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_completion", done_seen, 32'd0);

      issue(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, acc_cyc);
      wait_idle();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
